player_bullet: RTL and testbench

Player projectile controller that sits directly upstream of the `enemy` block. It launches a bullet from the player cannon on a fire press and moves it up the screen once per frame. It tests the bullet box against one enemy's bounding box and drives a one-cycle hit pulse into that enemy's `hit_i`. Its box outputs feed the pixel renderer.

---
 rtl/game_pkg.sv | 39 +++
 rtl/box_overlap.sv | 16 +
 rtl/player_bullet.sv | 164 ++++++++++++++++
 tb/tb_player_bullet.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types: screen geometry, bullet FSM states, box geometry and
// a helper that keeps a horizontally centred object inside the screen.
package game_pkg;

    localparam logic [9:0] SCREEN_W = 10'd640;
    localparam logic [9:0] SCREEN_H = 10'd480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        HIT  = 2'd2
    } bullet_state_e;

    // Inclusive pixel box.
    typedef struct packed {
        logic [9:0] left;
        logic [9:0] right;
        logic [9:0] top;
        logic [9:0] bot;
    } box_t;

    // Left edge for an object of half-width `half` centred on `center`,
    // limited to [0, max_left]. The low side is tested before subtracting
    // so the 10-bit difference can never wrap.
    function automatic logic [9:0] clamp_left(input logic [9:0] center,
                                              input logic [9:0] half,
                                              input logic [9:0] max_left);
        logic [9:0] raw;
        if (center < half) begin
            return 10'd0;
        end
        raw = center - half;
        if (raw > max_left) begin
            return max_left;
        end
        return raw;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational inclusive rectangle intersection of two boxes.
module box_overlap
    import game_pkg::*;
(
    input  box_t a_i,
    input  box_t b_i,
    output logic overlap_o
);

    // Boxes touch when they overlap on both axes; shared edges count.
    always_comb begin
        overlap_o = (a_i.left <= b_i.right) && (a_i.right >= b_i.left) &&
                    (a_i.top  <= b_i.bot)   && (a_i.bot   >= b_i.top);
    end

endmodule

// File: rtl/player_bullet.sv
// Player bullet controller: launches from the cannon on a fire edge, climbs
// speed_p pixels per frame, and emits a one-cycle hit pulse on contact with
// a live enemy. Positions hold while idle; the renderer gates on active_o.
module player_bullet
    import game_pkg::*;
#(
    parameter int          speed_p     = 4,
    parameter int          width_p     = 2,
    parameter int          height_p    = 8,
    parameter logic [9:0]  start_top_p = 10'd440,
    parameter logic [9:0]  screen_w_p  = 10'd640
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       fire_i,
    input  logic       frame_i,
    input  logic [9:0] player_center_i,
    input  logic [9:0] enemy_left_i,
    input  logic [9:0] enemy_right_i,
    input  logic [9:0] enemy_top_i,
    input  logic [9:0] enemy_bot_i,
    input  logic       enemy_dead_i,
    output logic [9:0] left_pos_o,
    output logic [9:0] right_pos_o,
    output logic [9:0] top_pos_o,
    output logic [9:0] bot_pos_o,
    output logic       active_o,
    output logic       hit_o
);

    localparam logic [9:0] SPEED    = 10'(speed_p);
    localparam logic [9:0] WIDTH    = 10'(width_p);
    localparam logic [9:0] HEIGHT   = 10'(height_p);
    localparam logic [9:0] HALF_W   = 10'(width_p / 2);
    localparam logic [9:0] MAX_LEFT = screen_w_p - WIDTH;
    localparam logic [9:0] TOP_INIT = start_top_p - HEIGHT;

    bullet_state_e state_q;
    bullet_state_e state_d;

    logic       fire_q;
    logic       fire_edge;
    logic [9:0] left_q;
    logic [9:0] top_q;
    logic [9:0] launch_left;
    box_t       bullet_box;
    box_t       enemy_box;
    logic       overlap;
    logic       hit_now;
    logic       expire_now;
    logic       step_now;

    assign fire_edge   = fire_i & ~fire_q;
    assign launch_left = clamp_left(player_center_i, HALF_W, MAX_LEFT);

    assign bullet_box.left  = left_q;
    assign bullet_box.right = left_q + WIDTH - 10'd1;
    assign bullet_box.top   = top_q;
    assign bullet_box.bot   = top_q + HEIGHT - 10'd1;

    assign enemy_box.left  = enemy_left_i;
    assign enemy_box.right = enemy_right_i;
    assign enemy_box.top   = enemy_top_i;
    assign enemy_box.bot   = enemy_bot_i;

    box_overlap u_box_overlap (
        .a_i       (bullet_box),
        .b_i       (enemy_box),
        .overlap_o (overlap)
    );

    // Flight decisions in priority order: a hit freezes the bullet even when
    // a frame arrives; otherwise a frame either retires the bullet (it would
    // cross row 0) or moves it up one step.
    assign hit_now    = overlap & ~enemy_dead_i;
    assign expire_now = ~hit_now & frame_i & (top_q < SPEED);
    assign step_now   = ~hit_now & frame_i & (top_q >= SPEED);

    // Previous fire level, for rising-edge detection.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fire_q <= 1'b0;
        end else begin
            fire_q <= fire_i;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; fire edges outside IDLE are simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fire_edge) begin
                    state_d = FLY;
                end
            end
            FLY: begin
                if (hit_now) begin
                    state_d = HIT;
                end else if (expire_now) begin
                    state_d = IDLE;
                end
            end
            HIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bullet position: loaded at launch, stepped upward while flying,
    // otherwise held so the last position stays on the outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            left_q <= 10'd0;
            top_q  <= TOP_INIT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire_edge) begin
                        left_q <= launch_left;
                        top_q  <= TOP_INIT;
                    end
                end
                FLY: begin
                    if (step_now) begin
                        top_q <= top_q - SPEED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        active_o = 1'b0;
        hit_o    = 1'b0;
        case (state_q)
            FLY:     active_o = 1'b1;
            HIT:     hit_o    = 1'b1;
            default: begin
            end
        endcase
    end

    assign left_pos_o  = bullet_box.left;
    assign right_pos_o = bullet_box.right;
    assign top_pos_o   = bullet_box.top;
    assign bot_pos_o   = bullet_box.bot;

endmodule

// File: tb/tb_player_bullet.sv
// Directed self-checking bench for player_bullet.
module tb_player_bullet;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       fire_i;
    logic       frame_i;
    logic [9:0] player_center_i;
    logic [9:0] enemy_left_i;
    logic [9:0] enemy_right_i;
    logic [9:0] enemy_top_i;
    logic [9:0] enemy_bot_i;
    logic       enemy_dead_i;
    logic [9:0] left_pos_o;
    logic [9:0] right_pos_o;
    logic [9:0] top_pos_o;
    logic [9:0] bot_pos_o;
    logic       active_o;
    logic       hit_o;

    int checks   = 0;
    int failures = 0;
    int hit_count    = 0;
    int launch_count = 0;
    logic active_d = 1'b0;

    player_bullet dut (
        .clk_i           (clk_i),
        .reset_ni        (reset_ni),
        .fire_i          (fire_i),
        .frame_i         (frame_i),
        .player_center_i (player_center_i),
        .enemy_left_i    (enemy_left_i),
        .enemy_right_i   (enemy_right_i),
        .enemy_top_i     (enemy_top_i),
        .enemy_bot_i     (enemy_bot_i),
        .enemy_dead_i    (enemy_dead_i),
        .left_pos_o      (left_pos_o),
        .right_pos_o     (right_pos_o),
        .top_pos_o       (top_pos_o),
        .bot_pos_o       (bot_pos_o),
        .active_o        (active_o),
        .hit_o           (hit_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (hit_o) hit_count++;
        if (active_o && !active_d) launch_count++;
        active_d = active_o;
    end

    typedef struct {
        logic [9:0] center;
        logic [9:0] exp_left;
        logic [9:0] exp_right;
    } clamp_vec_t;

    clamp_vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic frame();
        frame_i = 1'b1;
        step();
        frame_i = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset_ni = 1'b0;
        #1 reset_ni = 1'b1;
    endtask

    task automatic launch(input logic [9:0] center);
        player_center_i = center;
        fire_i = 1'b1;
        step();
        fire_i = 1'b0;
    endtask

    task automatic check_box(input string name, input logic [9:0] l, input logic [9:0] t);
        check({name, "_left"},  32'(left_pos_o),  32'(l));
        check({name, "_right"}, 32'(right_pos_o), 32'(l + 10'd1));
        check({name, "_top"},   32'(top_pos_o),   32'(t));
        check({name, "_bot"},   32'(bot_pos_o),   32'(t + 10'd7));
    endtask

    initial begin
        int h0;
        int l0;
        vecs[0] = '{10'd0,    10'd0,   10'd1};
        vecs[1] = '{10'd1,    10'd0,   10'd1};
        vecs[2] = '{10'd2,    10'd1,   10'd2};
        vecs[3] = '{10'd320,  10'd319, 10'd320};
        vecs[4] = '{10'd637,  10'd636, 10'd637};
        vecs[5] = '{10'd638,  10'd637, 10'd638};
        vecs[6] = '{10'd639,  10'd638, 10'd639};
        vecs[7] = '{10'd700,  10'd638, 10'd639};
        vecs[8] = '{10'd1023, 10'd638, 10'd639};

        reset_ni = 1'b0;
        fire_i = 1'b0;
        frame_i = 1'b0;
        player_center_i = 10'd320;
        enemy_left_i = 10'd0;
        enemy_right_i = 10'd0;
        enemy_top_i = 10'd0;
        enemy_bot_i = 10'd0;
        enemy_dead_i = 1'b1;

        // Reset state
        #12;
        check_box("reset", 10'd0, 10'd432);
        check("reset_active", 32'(active_o), 32'd0);
        check("reset_hit", 32'(hit_o), 32'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        step();
        check("idle_after_release", 32'(active_o), 32'd0);

        // Launch at 320 and fly off the top with no live enemy
        h0 = hit_count;
        launch(10'd320);
        check("launch_active", 32'(active_o), 32'd1);
        check("launch_hit", 32'(hit_o), 32'd0);
        check_box("launch", 10'd319, 10'd432);
        step();
        check("no_move_without_frame", 32'(top_pos_o), 32'd432);
        for (int i = 0; i < 108; i++) frame();
        check("expire_top0", 32'(top_pos_o), 32'd0);
        check("expire_still_active", 32'(active_o), 32'd1);
        frame();
        check("expire_active", 32'(active_o), 32'd0);
        check("expire_top_hold", 32'(top_pos_o), 32'd0);
        check("expire_no_hit", 32'(hit_count - h0), 32'd0);

        // Clamp table
        foreach (vecs[i]) begin
            do_reset();
            launch(vecs[i].center);
            check($sformatf("clamp%0d_active", i), 32'(active_o), 32'd1);
            check($sformatf("clamp%0d_left", i),  32'(left_pos_o),  32'(vecs[i].exp_left));
            check($sformatf("clamp%0d_right", i), 32'(right_pos_o), 32'(vecs[i].exp_right));
            step();
        end

        // Hit after 80 frames
        do_reset();
        enemy_left_i = 10'd310;
        enemy_right_i = 10'd330;
        enemy_top_i = 10'd100;
        enemy_bot_i = 10'd115;
        enemy_dead_i = 1'b0;
        h0 = hit_count;
        launch(10'd320);
        for (int i = 0; i < 79; i++) frame();
        check("hit_pre_top", 32'(top_pos_o), 32'd116);
        check("hit_pre_none", 32'(hit_count - h0), 32'd0);
        frame();
        check("hit_f80_top", 32'(top_pos_o), 32'd112);
        check("hit_f80_active", 32'(active_o), 32'd1);
        check("hit_f80_hit", 32'(hit_o), 32'd0);
        step();
        check("hit_pulse", 32'(hit_o), 32'd1);
        check("hit_pulse_active", 32'(active_o), 32'd0);
        check("hit_pulse_top", 32'(top_pos_o), 32'd112);
        step();
        check("hit_after", 32'(hit_o), 32'd0);
        check("hit_after_active", 32'(active_o), 32'd0);
        step();
        check("hit_count_one", 32'(hit_count - h0), 32'd1);

        // Held fire launches once; a later edge in flight is dropped
        do_reset();
        enemy_dead_i = 1'b1;
        step();
        l0 = launch_count;
        player_center_i = 10'd200;
        fire_i = 1'b1;
        for (int i = 0; i < 500; i++) step();
        check("hold_active", 32'(active_o), 32'd1);
        for (int i = 0; i < 5; i++) frame();
        check("hold_top", 32'(top_pos_o), 32'd412);
        fire_i = 1'b0;
        step();
        player_center_i = 10'd50;
        fire_i = 1'b1;
        step();
        fire_i = 1'b0;
        step();
        check("refire_top", 32'(top_pos_o), 32'd412);
        check("refire_left", 32'(left_pos_o), 32'd199);
        check("launch_count_one", 32'(launch_count - l0), 32'd1);

        // Overlap and frame in the same cycle: hit wins, no movement
        do_reset();
        enemy_left_i = 10'd300;
        enemy_right_i = 10'd340;
        enemy_top_i = 10'd430;
        enemy_bot_i = 10'd450;
        enemy_dead_i = 1'b0;
        launch(10'd320);
        frame();
        check("same_hit", 32'(hit_o), 32'd1);
        check("same_top", 32'(top_pos_o), 32'd432);
        step();
        check("same_idle", 32'(active_o | hit_o), 32'd0);

        // Async reset mid-hit
        launch(10'd320);
        step();
        check("midhit_hit", 32'(hit_o), 32'd1);
        #2 reset_ni = 1'b0;
        #1;
        check("midhit_reset_hit", 32'(hit_o), 32'd0);
        reset_ni = 1'b1;

        // Async reset mid-flight
        enemy_dead_i = 1'b1;
        step();
        launch(10'd100);
        frame();
        frame();
        check("midfly_top", 32'(top_pos_o), 32'd424);
        h0 = hit_count;
        #2 reset_ni = 1'b0;
        #1;
        check("midfly_active", 32'(active_o), 32'd0);
        check("midfly_hit", 32'(hit_o), 32'd0);
        check_box("midfly", 10'd0, 10'd432);
        step();
        step();
        check("midfly_no_hit", 32'(hit_count - h0), 32'd0);
        reset_ni = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
